// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_pkg
//  Description : Shared definitions for the interrupt path. Holds the
//                interrupt-kind encoding, the arbiter state encoding, the
//                three low vector addresses and a kind-to-vector helper.
//                Also imported by the interrupt handler.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_pkg;

    typedef enum logic [1:0] {
        KIND_NONE    = 2'd0,
        KIND_RST     = 2'd1,
        KIND_NMI     = 2'd2,
        KIND_BRK_IRQ = 2'd3
    } int_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } arb_state_t;

    localparam logic [15:0] c_vec_rst  = 16'hFFFC;
    localparam logic [15:0] c_vec_nmi  = 16'hFFFA;
    localparam logic [15:0] c_vec_brk  = 16'hFFFE;
    localparam logic [15:0] c_vec_none = 16'h0000;

    function automatic logic [15:0] kind_vector(input int_kind_t kind);
        logic [15:0] v;
        case (kind)
            KIND_RST:     v = c_vec_rst;
            KIND_NMI:     v = c_vec_nmi;
            KIND_BRK_IRQ: v = c_vec_brk;
            default:      v = c_vec_none;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_sync.sv
`default_nettype none
// ============================================================================
//  Module      : int_sync
//  Description : Single-bit flop-chain synchronizer for asynchronous inputs.
//                Output follows the input after STAGES clock edges.
//  Ports       : clk, rst (sync, active high), d (async input),
//                q (synchronized output)
//  Revision    : 1.0 - initial release
// ============================================================================
module int_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/int_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : int_request_arbiter
//  Description : Collects RST / NMI / BRK / IRQ sources, arbitrates them with
//                fixed priority RST > NMI > BRK > IRQ and hands one request
//                at a time to the interrupt handler through an
//                IDLE -> REQ -> SERVICE handshake.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                halt             - freeze FSM and pending latches
//                ppu_status[7]    - vblank flag
//                ppu_ctrl1[7]     - NMI enable
//                nIRQ             - external IRQ, active low, asynchronous
//                irq_src[2:0]     - internal IRQ levels, active high
//                break_in         - BRK decode pulse
//                soft_reset_n     - soft reset request, active low
//                status_in[2]     - CPU I flag
//                instr_boundary   - current instruction retired
//                svc_done         - handler finished
//                int_req          - request to the handler
//                int_kind         - NONE / RST / NMI / BRK_IRQ
//                vector_addr      - low vector address
//                is_break         - serviced request is BRK
//                nmi_pending, irq_level - debug visibility
//  Revision    : 1.0 - initial release
// ============================================================================
module int_request_arbiter
    import int_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [7:0]  ppu_status,
    input  logic [7:0]  ppu_ctrl1,
    input  logic        nIRQ,
    input  logic [2:0]  irq_src,
    input  logic        break_in,
    input  logic        soft_reset_n,
    input  logic [7:0]  status_in,
    input  logic        instr_boundary,
    input  logic        svc_done,
    output logic        int_req,
    output logic [1:0]  int_kind,
    output logic [15:0] vector_addr,
    output logic        is_break,
    output logic        nmi_pending,
    output logic        irq_level
);

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic       w_nirq_s;
    logic [2:0] w_src_s;

    int_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_nirq (
        .clk (clk),
        .rst (rst),
        .d   (nIRQ),
        .q   (w_nirq_s)
    );

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src_sync
            int_sync #(
                .STAGES    (SYNC_STAGES),
                .RESET_VAL (1'b0)
            ) u_sync_src (
                .clk (clk),
                .rst (rst),
                .d   (irq_src[gi]),
                .q   (w_src_s[gi])
            );
        end
    endgenerate

    assign irq_level = ~w_nirq_s | (|w_src_s);

    // ------------------------------------------------------------------
    // NMI edge detection
    // ------------------------------------------------------------------
    logic w_nmi_line;
    logic w_nmi_edge;
    logic r_nmi_prev;
    logic r_edge_armed;
    logic r_nmi_defer;

    assign w_nmi_line = ppu_status[7] & ppu_ctrl1[7];

    // The history is cleared by reset, so the first cycle afterwards would
    // see a false rising edge if the line is already high. r_edge_armed
    // masks that cycle; only a genuine low-to-high transition counts.
    assign w_nmi_edge = w_nmi_line & ~r_nmi_prev & r_edge_armed;

    // Edge history keeps running under halt. An edge seen while halted is
    // parked in r_nmi_defer and delivered to the pending latch on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_prev   <= 1'b0;
            r_edge_armed <= 1'b0;
            r_nmi_defer  <= 1'b0;
        end else begin
            r_nmi_prev   <= w_nmi_line;
            r_edge_armed <= 1'b1;
            if (halt) begin
                r_nmi_defer <= r_nmi_defer | w_nmi_edge;
            end else begin
                r_nmi_defer <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending latches and arbitration
    // ------------------------------------------------------------------
    arb_state_t r_state;
    logic       r_rst_pend;
    logic       r_nmi_pend;
    logic       r_brk_pend;

    logic       w_irq_elig;
    logic       w_any;
    int_kind_t  w_kind;
    logic       w_brk_wins;
    logic       w_take;
    logic       w_rst_set, w_nmi_set, w_brk_set;
    logic       w_rst_clr, w_nmi_clr, w_brk_clr;

    assign w_irq_elig = irq_level & ~status_in[2];
    assign w_any      = r_rst_pend | r_nmi_pend | r_brk_pend | w_irq_elig;

    always_comb begin
        w_kind = KIND_NONE;
        if (r_rst_pend) begin
            w_kind = KIND_RST;
        end else if (r_nmi_pend) begin
            w_kind = KIND_NMI;
        end else if (r_brk_pend | w_irq_elig) begin
            w_kind = KIND_BRK_IRQ;
        end
    end

    // BRK shares the BRK_IRQ kind with IRQ but outranks it.
    assign w_brk_wins = (w_kind == KIND_BRK_IRQ) & r_brk_pend;

    // Acceptance into SERVICE this cycle.
    assign w_take = ~halt & (r_state == ST_REQ) & instr_boundary & w_any;

    assign w_rst_set = ~halt & ~soft_reset_n;
    assign w_nmi_set = ~halt & (w_nmi_edge | r_nmi_defer);
    assign w_brk_set = ~halt & break_in;

    assign w_rst_clr = w_take & (w_kind == KIND_RST);
    assign w_nmi_clr = w_take & (w_kind == KIND_NMI);
    assign w_brk_clr = w_take & w_brk_wins;

    // A set arriving in the same cycle as a clear wins, so a fresh event is
    // never swallowed by the acceptance of an older one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_pend <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else begin
            r_rst_pend <= w_rst_set | (r_rst_pend & ~w_rst_clr);
            r_nmi_pend <= w_nmi_set | (r_nmi_pend & ~w_nmi_clr);
            r_brk_pend <= w_brk_set | (r_brk_pend & ~w_brk_clr);
        end
    end

    assign nmi_pending = r_nmi_pend;

    // ------------------------------------------------------------------
    // Request FSM with registered outputs
    // ------------------------------------------------------------------
    logic        r_int_req;
    int_kind_t   r_kind;
    logic [15:0] r_vector;
    logic        r_is_break;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_int_req  <= 1'b0;
            r_kind     <= KIND_NONE;
            r_vector   <= c_vec_none;
            r_is_break <= 1'b0;
        end else if (!halt) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state    <= ST_REQ;
                        r_int_req  <= 1'b1;
                        r_kind     <= w_kind;
                        r_vector   <= kind_vector(w_kind);
                        r_is_break <= w_brk_wins;
                    end
                end
                ST_REQ: begin
                    if (!w_any) begin
                        // Source withdrawn before the boundary (IRQ dropped
                        // or masked): abandon without servicing.
                        r_state    <= ST_IDLE;
                        r_int_req  <= 1'b0;
                        r_kind     <= KIND_NONE;
                        r_vector   <= c_vec_none;
                        r_is_break <= 1'b0;
                    end else begin
                        r_kind     <= w_kind;
                        r_vector   <= kind_vector(w_kind);
                        r_is_break <= w_brk_wins;
                        if (instr_boundary) begin
                            r_state <= ST_SERVICE;
                        end
                    end
                end
                ST_SERVICE: begin
                    if (svc_done) begin
                        r_state    <= ST_IDLE;
                        r_int_req  <= 1'b0;
                        r_kind     <= KIND_NONE;
                        r_vector   <= c_vec_none;
                        r_is_break <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_int_req  <= 1'b0;
                    r_kind     <= KIND_NONE;
                    r_vector   <= c_vec_none;
                    r_is_break <= 1'b0;
                end
            endcase
        end
    end

    assign int_req     = r_int_req;
    assign int_kind    = r_kind;
    assign vector_addr = r_vector;
    assign is_break    = r_is_break;

endmodule
`default_nettype wire

// File: tb/tb_int_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_request_arbiter
//  Description : Directed self-checking bench for int_request_arbiter.
//                Inputs change 1 ns after a rising edge; outputs are checked
//                at the same point, i.e. they reflect the state after the
//                preceding edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_request_arbiter;

    logic        clk;
    logic        rst;
    logic        halt;
    logic [7:0]  ppu_status;
    logic [7:0]  ppu_ctrl1;
    logic        nIRQ;
    logic [2:0]  irq_src;
    logic        break_in;
    logic        soft_reset_n;
    logic [7:0]  status_in;
    logic        instr_boundary;
    logic        svc_done;
    logic        int_req;
    logic [1:0]  int_kind;
    logic [15:0] vector_addr;
    logic        is_break;
    logic        nmi_pending;
    logic        irq_level;

    int n_checks = 0;
    int n_bad    = 0;

    int_request_arbiter #(
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .ppu_status     (ppu_status),
        .ppu_ctrl1      (ppu_ctrl1),
        .nIRQ           (nIRQ),
        .irq_src        (irq_src),
        .break_in       (break_in),
        .soft_reset_n   (soft_reset_n),
        .status_in      (status_in),
        .instr_boundary (instr_boundary),
        .svc_done       (svc_done),
        .int_req        (int_req),
        .int_kind       (int_kind),
        .vector_addr    (vector_addr),
        .is_break       (is_break),
        .nmi_pending    (nmi_pending),
        .irq_level      (irq_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic req, input logic [1:0] kind,
                             input logic [15:0] vec, input logic brk);
        check({tag, ".int_req"},  32'(int_req),     32'(req));
        check({tag, ".int_kind"}, 32'(int_kind),    32'(kind));
        check({tag, ".vector"},   32'(vector_addr), 32'(vec));
        check({tag, ".is_break"}, 32'(is_break),    32'(brk));
    endtask

    initial begin
        rst            = 1'b1;
        halt           = 1'b0;
        ppu_status     = 8'h00;
        ppu_ctrl1      = 8'h00;
        nIRQ           = 1'b1;
        irq_src        = 3'b000;
        break_in       = 1'b0;
        soft_reset_n   = 1'b1;
        status_in      = 8'h00;
        instr_boundary = 1'b0;
        svc_done       = 1'b0;

        // ---------------- reset state ----------------
        tick(3);
        check_req("reset", 1'b0, 2'd0, 16'h0000, 1'b0);
        check("reset.nmi_pending", 32'(nmi_pending), 32'd0);
        check("reset.irq_level",   32'(irq_level),   32'd0);
        rst = 1'b0;
        tick(2);
        check("post_reset.int_req", 32'(int_req), 32'd0);

        // ---------------- NMI basic timing ----------------
        ppu_status = 8'h80; ppu_ctrl1 = 8'h80;          // cycle 10
        tick(1);                                        // 11
        check("nmi.pending_c11", 32'(nmi_pending), 32'd1);
        check("nmi.req_c11",     32'(int_req),     32'd0);
        tick(1);                                        // 12
        check_req("nmi.req_c12", 1'b1, 2'd2, 16'hFFFA, 1'b0);
        tick(2);                                        // 14
        instr_boundary = 1'b1;
        tick(1);                                        // 15
        instr_boundary = 1'b0;
        check("nmi.pending_cleared", 32'(nmi_pending), 32'd0);
        check_req("nmi.service", 1'b1, 2'd2, 16'hFFFA, 1'b0);
        tick(5);                                        // 20
        svc_done = 1'b1;
        tick(1);                                        // 21
        svc_done = 1'b0;
        check_req("nmi.idle_c21", 1'b0, 2'd0, 16'h0000, 1'b0);
        tick(1);
        check("nmi.held_no_retrigger", 32'(int_req), 32'd0);
        ppu_status = 8'h00;
        tick(1);

        // ---------------- IRQ masked before boundary ----------------
        nIRQ = 1'b0;
        tick(2);
        check("irq.level", 32'(irq_level), 32'd1);
        tick(1);
        check_req("irq.req", 1'b1, 2'd3, 16'hFFFE, 1'b0);
        status_in = 8'h04;
        tick(1);
        check("irq.masked_req", 32'(int_req), 32'd0);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        check_req("irq.no_service", 1'b0, 2'd0, 16'h0000, 1'b0);
        nIRQ = 1'b1;
        tick(3);
        check("irq.level_low", 32'(irq_level), 32'd0);
        status_in = 8'h00;
        tick(1);
        check("irq.idle", 32'(int_req), 32'd0);

        // ---------------- BRK + NMI in the same cycle ----------------
        ppu_status = 8'h80; break_in = 1'b1;
        tick(1);
        break_in = 1'b0;
        check("brknmi.nmi_pending", 32'(nmi_pending), 32'd1);
        tick(1);
        check_req("brknmi.nmi_req", 1'b1, 2'd2, 16'hFFFA, 1'b0);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        check_req("brknmi.nmi_svc", 1'b1, 2'd2, 16'hFFFA, 1'b0);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        check("brknmi.gap", 32'(int_req), 32'd0);
        tick(1);
        check_req("brknmi.brk_req", 1'b1, 2'd3, 16'hFFFE, 1'b1);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        check_req("brknmi.brk_svc", 1'b1, 2'd3, 16'hFFFE, 1'b1);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        tick(1);
        check("brknmi.done", 32'(int_req), 32'd0);
        ppu_status = 8'h00;
        tick(1);

        // ---------------- soft reset outranks pending NMI ----------------
        ppu_status = 8'h80; soft_reset_n = 1'b0;
        tick(1);
        soft_reset_n = 1'b1;
        check("rstnmi.nmi_pending", 32'(nmi_pending), 32'd1);
        tick(1);
        check_req("rstnmi.rst_req", 1'b1, 2'd1, 16'hFFFC, 1'b0);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        check_req("rstnmi.rst_svc", 1'b1, 2'd1, 16'hFFFC, 1'b0);
        check("rstnmi.nmi_kept", 32'(nmi_pending), 32'd1);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        check("rstnmi.gap", 32'(int_req), 32'd0);
        tick(1);
        check_req("rstnmi.nmi_req", 1'b1, 2'd2, 16'hFFFA, 1'b0);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        ppu_status = 8'h00;
        tick(1);
        check("rstnmi.idle", 32'(int_req), 32'd0);

        // ---------------- NMI during IRQ service ----------------
        irq_src = 3'b010;
        tick(2);
        check("irqsvc.level", 32'(irq_level), 32'd1);
        tick(1);
        check_req("irqsvc.req", 1'b1, 2'd3, 16'hFFFE, 1'b0);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        ppu_status = 8'h80;
        tick(1);
        check("irqsvc.nmi_latched", 32'(nmi_pending), 32'd1);
        check_req("irqsvc.frozen1", 1'b1, 2'd3, 16'hFFFE, 1'b0);
        irq_src = 3'b000;
        tick(2);
        check_req("irqsvc.frozen2", 1'b1, 2'd3, 16'hFFFE, 1'b0);
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        check("irqsvc.gap", 32'(int_req), 32'd0);
        tick(1);
        check_req("irqsvc.nmi_req", 1'b1, 2'd2, 16'hFFFA, 1'b0);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        ppu_status = 8'h00;
        tick(1);

        // ---------------- rst during SERVICE, held vblank ----------------
        ppu_status = 8'h80;
        tick(2);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        check("rstsvc.in_service", 32'(int_req), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_req("rstsvc.reset", 1'b0, 2'd0, 16'h0000, 1'b0);
        check("rstsvc.nmi_pending", 32'(nmi_pending), 32'd0);
        tick(3);
        check("rstsvc.no_retrigger_pend", 32'(nmi_pending), 32'd0);
        check("rstsvc.no_retrigger_req",  32'(int_req),     32'd0);

        // ---------------- edge during halt is not lost ----------------
        ppu_status = 8'h00;
        tick(1);
        halt = 1'b1;
        ppu_status = 8'h80;
        tick(1);
        check("halt.pending_held", 32'(nmi_pending), 32'd0);
        halt = 1'b0;
        tick(1);
        check("halt.pending_after", 32'(nmi_pending), 32'd1);
        tick(1);
        check_req("halt.nmi_req", 1'b1, 2'd2, 16'hFFFA, 1'b0);
        instr_boundary = 1'b1;
        tick(1);
        instr_boundary = 1'b0;
        svc_done = 1'b1;
        tick(1);
        svc_done = 1'b0;
        check("halt.idle", 32'(int_req), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
